montar_senha: RTL and testbench

- Keypad-side packer that collects digit keypresses and assembles a four-digit PIN.
- Presents the PIN as a pinPac_t packet to the password verifier, with a status pulse whose rising edge triggers verification.
- Sits between the keypad decoder and the verifier.
- Owns:
  - digit ordering
  - clear/enter keys
  - inactivity timeout
  - the status framing the verifier edge-detects.

---
 rtl/montar_senha_pkg.sv | 29 ++
 rtl/montar_senha_if.sv | 23 ++
 rtl/montar_senha_contador_timeout.sv | 30 +++
 rtl/montar_senha.sv | 137 +++++++++++++
 tb/tb_montar_senha.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/montar_senha_pkg.sv
// rtl/montar_senha_pkg.sv - shared keypad/verifier packet types, key codes and packer state encoding.
package montar_senha_pkg;

  localparam logic [3:0] KEY_CLEAR   = 4'hA;
  localparam logic [3:0] KEY_ENTER   = 4'hB;
  localparam logic [3:0] BLANK_DIGIT = 4'b1111;

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;

  typedef logic [1:0] montar_state_t;
  localparam montar_state_t ST_IDLE    = 2'd0;
  localparam montar_state_t ST_COLLECT = 2'd1;
  localparam montar_state_t ST_SEND    = 2'd2;
  localparam montar_state_t ST_GAP     = 2'd3;

  localparam pinPac_t PIN_BLANK = '{status: 1'b0, digit1: BLANK_DIGIT, digit2: BLANK_DIGIT,
                                    digit3: BLANK_DIGIT, digit4: BLANK_DIGIT};

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/montar_senha_if.sv
// rtl/montar_senha_if.sv - keypad-in / verifier-out bundle of the PIN packer.
interface montar_senha_if;
  import montar_senha_pkg::*;

  logic       key_valid;
  logic [3:0] key_code;
  logic       enable;
  pinPac_t    pin_out;
  logic [2:0] digit_count;
  logic       entry_error;
  logic       entry_timeout;

  modport master (
    output key_valid, key_code, enable,
    input  pin_out, digit_count, entry_error, entry_timeout
  );

  modport slave (
    input  key_valid, key_code, enable,
    output pin_out, digit_count, entry_error, entry_timeout
  );

endinterface

// File: rtl/montar_senha_contador_timeout.sv
// rtl/montar_senha_contador_timeout.sv - cycle counter giving a one-cycle expiry after LIMIT run cycles.
module contador_timeout #(
  parameter int LIMIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int             W    = $clog2(LIMIT + 1);
  localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expired) cnt_d = '0;
    else if (run)         cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/montar_senha.sv
// rtl/montar_senha.sv - packs four keypad digits into a pinPac_t; AUTO_SUBMIT_EN submits on the 4th digit.
module montar_senha
  import montar_senha_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int STATUS_CYCLES  = 2
) (
  input  logic           clk,
  input  logic           rst,
  montar_senha_if.slave  bus
);

  montar_state_t state_q, state_d;
  pinPac_t       pin_q, pin_d;
  logic [2:0]    count_q, count_d;
  logic          error_q, error_d;
  logic          timeout_q, timeout_d;

  logic key_ok, key_dig, key_clr, key_ent;
  logic idle_run, idle_exp, hold_run, hold_exp;

  // Codes 0xC-0xF never count as a keypress, so they do not restart the idle timer either.
  assign key_ok  = bus.key_valid && bus.enable && (bus.key_code <= KEY_ENTER);
  assign key_dig = key_ok && is_digit(bus.key_code);
  assign key_clr = key_ok && (bus.key_code == KEY_CLEAR);
  assign key_ent = key_ok && (bus.key_code == KEY_ENTER);

  assign idle_run = (state_q == ST_COLLECT) && bus.enable && !key_ok;
  assign hold_run = (state_q == ST_SEND);

  contador_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_idle (
    .clk(clk), .rst(rst), .clear(!idle_run), .run(idle_run), .expired(idle_exp)
  );

  contador_timeout #(.LIMIT(STATUS_CYCLES)) u_hold (
    .clk(clk), .rst(rst), .clear(!hold_run), .run(hold_run), .expired(hold_exp)
  );

  always_comb begin
    state_d   = state_q;
    pin_d     = pin_q;
    count_d   = count_q;
    error_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_dig) begin
          pin_d.digit1 = bus.key_code;
          count_d      = 3'd1;
          state_d      = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (key_dig) begin
          case (count_q)
            3'd1:    pin_d.digit2 = bus.key_code;
            3'd2:    pin_d.digit3 = bus.key_code;
            3'd3:    pin_d.digit4 = bus.key_code;
            default: begin
              pin_d.digit1 = pin_q.digit2;
              pin_d.digit2 = pin_q.digit3;
              pin_d.digit3 = pin_q.digit4;
              pin_d.digit4 = bus.key_code;
            end
          endcase
          if (count_q != 3'd4) count_d = count_q + 3'd1;
`ifdef AUTO_SUBMIT_EN
          if (count_q == 3'd3) begin
            pin_d.status = 1'b1;
            state_d      = ST_SEND;
          end
`endif
        end else if (key_clr) begin
          pin_d   = PIN_BLANK;
          count_d = 3'd0;
          state_d = ST_IDLE;
        end else if (key_ent) begin
          if (count_q == 3'd4) begin
            pin_d.status = 1'b1;
            state_d      = ST_SEND;
          end else begin
            error_d = 1'b1;
            pin_d   = PIN_BLANK;
            count_d = 3'd0;
            state_d = ST_IDLE;
          end
        end else if (idle_exp) begin
          timeout_d = 1'b1;
          pin_d     = PIN_BLANK;
          count_d   = 3'd0;
          state_d   = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (hold_exp) begin
          pin_d.status = 1'b0;
          state_d      = ST_GAP;
        end
      end
      default: begin
        pin_d   = PIN_BLANK;
        count_d = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
    // A packet already on the wire always runs to completion.
    if (!bus.enable && (state_q != ST_SEND)) begin
      pin_d     = PIN_BLANK;
      count_d   = 3'd0;
      state_d   = ST_IDLE;
      error_d   = 1'b0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pin_q     <= PIN_BLANK;
      count_q   <= 3'd0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pin_q     <= pin_d;
      count_q   <= count_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.pin_out       = pin_q;
  assign bus.digit_count   = count_q;
  assign bus.entry_error   = error_q;
  assign bus.entry_timeout = timeout_q;

endmodule

// File: tb/tb_montar_senha.sv
// tb/tb_montar_senha.sv - directed vector bench for montar_senha (TIMEOUT_CYCLES=10, STATUS_CYCLES=2).
module tb_montar_senha;
  import montar_senha_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  montar_senha_if bus ();

  montar_senha #(.TIMEOUT_CYCLES(10), .STATUS_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [2:0]  cnt;
    logic [15:0] digits;
    logic        err;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic st, input logic [15:0] dg,
                            input logic [2:0] cnt, input logic err, input logic to);
    chk({name, ".status"}, 32'(bus.pin_out.status), 32'(st));
    chk({name, ".digits"}, 32'({bus.pin_out.digit1, bus.pin_out.digit2,
                                bus.pin_out.digit3, bus.pin_out.digit4}), 32'(dg));
    chk({name, ".count"},  32'(bus.digit_count), 32'(cnt));
    chk({name, ".error"},  32'(bus.entry_error), 32'(err));
    chk({name, ".timeout"}, 32'(bus.entry_timeout), 32'(to));
  endtask

  // Drive one key for one cycle; returns at the negedge after it was sampled.
  task automatic key(input logic [3:0] c);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.enable    = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;

    tbl[0]  = '{4'h3, 3'd1, 16'h3FFF, 1'b0};
    tbl[1]  = '{4'hA, 3'd0, 16'hFFFF, 1'b0};
    tbl[2]  = '{4'h5, 3'd1, 16'h5FFF, 1'b0};
    tbl[3]  = '{4'h6, 3'd2, 16'h56FF, 1'b0};
    tbl[4]  = '{4'h7, 3'd3, 16'h567F, 1'b0};
    tbl[5]  = '{4'hC, 3'd3, 16'h567F, 1'b0};
    tbl[6]  = '{4'h8, 3'd4, 16'h5678, 1'b0};
    tbl[7]  = '{4'h9, 3'd4, 16'h6789, 1'b0};
    tbl[8]  = '{4'hF, 3'd4, 16'h6789, 1'b0};
    tbl[9]  = '{4'hA, 3'd0, 16'hFFFF, 1'b0};
    tbl[10] = '{4'hB, 3'd0, 16'hFFFF, 1'b0};
    tbl[11] = '{4'h1, 3'd1, 16'h1FFF, 1'b0};
    tbl[12] = '{4'h2, 3'd2, 16'h12FF, 1'b0};
    tbl[13] = '{4'hB, 3'd0, 16'hFFFF, 1'b1};
    tbl[14] = '{4'hA, 3'd0, 16'hFFFF, 1'b0};
    tbl[15] = '{4'h4, 3'd1, 16'h4FFF, 1'b0};
    tbl[16] = '{4'hA, 3'd0, 16'hFFFF, 1'b0};

    repeat (2) @(negedge clk);
    expect_out("reset", 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      key(tbl[i].code);
      expect_out($sformatf("vec%0d", i), 1'b0, tbl[i].digits, tbl[i].cnt, tbl[i].err, 1'b0);
    end

    // Basic packet; keys during SEND/GAP are dropped.
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    key(KEY_ENTER);
    expect_out("pkt.s1", 1'b1, 16'h1234, 3'd4, 1'b0, 1'b0);
    key(4'h9);
    expect_out("pkt.s2", 1'b1, 16'h1234, 3'd4, 1'b0, 1'b0);
    key(4'h5);
    expect_out("pkt.gap", 1'b0, 16'h1234, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("pkt.idle", 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0);

    // Shift keeps the latest four digits.
    key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'h5); key(4'h4);
    key(KEY_ENTER);
    expect_out("shf.s1", 1'b1, 16'h7654, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("shf.s2", 1'b1, 16'h7654, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("shf.gap", 1'b0, 16'h7654, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("shf.idle", 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0);

    // Inactivity timeout 10 cycles after the last key.
    key(4'h7);
    expect_out("to.key", 1'b0, 16'h7FFF, 3'd1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("to.c%0d", i), 32'(bus.entry_timeout), 32'(i == 10));
    end
    expect_out("to.blank", 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("to.pulse_end", 32'(bus.entry_timeout), 32'd0);

    // A key at cycle 9 restarts the count.
    key(4'h7);
    repeat (8) @(negedge clk);
    key(4'h8);
    expect_out("rs.key", 1'b0, 16'h78FF, 3'd2, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("rs.c%0d", i), 32'(bus.entry_timeout), 32'(i == 10));
    end
    chk("rs.count", 32'(bus.digit_count), 32'd0);

    // enable low discards the entry and ignores keys.
    key(4'h1); key(4'h2);
    bus.enable = 1'b0;
    key(4'h3);
    expect_out("en.off", 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0);
    bus.enable = 1'b1;
    key(4'h4);
    expect_out("en.on", 1'b0, 16'h4FFF, 3'd1, 1'b0, 1'b0);
    key(KEY_CLEAR);

    // enable low during SEND does not truncate the packet.
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    key(KEY_ENTER);
    bus.enable = 1'b0;
    @(negedge clk);
    expect_out("ens.s2", 1'b1, 16'h1234, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("ens.gap", 1'b0, 16'h1234, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("ens.idle", 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0);
    bus.enable = 1'b1;

    // Asynchronous reset mid-SEND drops status at once.
    key(4'h5); key(4'h6); key(4'h7); key(4'h8);
    key(KEY_ENTER);
    expect_out("rst.send", 1'b1, 16'h5678, 3'd4, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 expect_out("rst.async", 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    key(4'h0); key(4'h0); key(4'h0); key(4'h0);
    key(KEY_ENTER);
    expect_out("rst.pkt1", 1'b1, 16'h0000, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rst.pkt2", 1'b1, 16'h0000, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rst.gap", 1'b0, 16'h0000, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rst.idle", 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
